mpu_store: RTL
==============

// Module: mpu_store
//
// PURPOSE
//   Store-back stage of the MPU. It reads one matrix from the matrix register
//   file and streams its elements, one per accepted beat, to memory or a file
//   sink. Elements are emitted in row-major order.
//   It sits directly downstream of the register file and mirrors the load
//   stage, which streams elements into the register file.
//
// PARAMETERS
//   FP               32  element width in bits (IEEE-754 single)
//   M                4   max matrix rows held by the register file
//   N                4   max matrix columns held by the register file
//   MBITS            2   $clog2(M); the row-size port is MBITS+1 bits wide
//   NBITS            2   $clog2(N); the column-size port is NBITS+1 bits wide
//   MATRIX_REG_SIZE  2   register-file address width
//
// PORTS
//   clk             in   1                      single clock, rising edge
//   rst             in   1                      async reset, ACTIVE-LOW
//   en              in   1                      start request, sampled in IDLE
//   store_addr      in   MATRIX_REG_SIZE        register-file slot to read
//   matrix_m_size   in   MBITS+1                rows to emit
//   matrix_n_size   in   NBITS+1                columns to emit
//   reg_store_addr  out  MATRIX_REG_SIZE        read address to the register file
//   matrix_in       in   FP x [M][N]            register-file matrix_out
//   element_out     out  FP                     current element
//   valid           out  1                      element_out is valid
//   ready           in   1                      sink accepts element_out
//   busy            out  1                      high in any state other than IDLE
//   ack             out  1                      1-cycle pulse, last element accepted
//   error           out  1                      1-cycle pulse, request rejected
//
// BEHAVIOUR
// - Reset (rst=0, async): state=IDLE; every output, reg_store_addr and the
//   row/column counters are 0; the snapshot buffer is cleared.
// - States: IDLE -> FETCH -> STREAM -> DONE -> IDLE. IDLE also exits to ERR,
//   and ERR returns to IDLE.
// - IDLE:
//   - en=1 with 1<=m<=M and 1<=n<=N: latch store_addr, m and n; go to FETCH.
//   - en=1 with m=0, n=0, m>M or n>N: go to ERR. No valid is ever raised.
//   - en=1 while busy is ignored; it is not queued.
// - FETCH (1 cycle):
//   - Drive reg_store_addr with the latched address.
//   - At the next edge, copy matrix_in into the local snapshot and go to STREAM.
//   - Later register-file writes do not affect the stream.
// - STREAM:
//   - valid=1 and element_out=snapshot[row][col]. Counters start at 0,0.
//   - Beat = valid & ready at a rising edge. On each beat, col increments;
//     at col=n-1 it wraps to 0 and row increments.
//   - While valid & !ready, element_out and the counters hold stable.
//   - The beat at row=m-1, col=n-1 goes to DONE and drops valid on the
//     same edge.
// - DONE (1 cycle): ack=1, then go to IDLE.
// - ERR (1 cycle): error=1, then go to IDLE.
// - Latency: en sampled at edge k; valid is high after edge k+1. With ready
//   held high, ack is high during the cycle after the final beat. Total time
//   from en to ack is m*n+2 cycles.
// - Elements are passed through bit-exact. No FP arithmetic is performed.
// - Reset mid-operation: valid, busy and ack drop immediately, asynchronously.
//   No partial ack or error is produced afterwards.
// - ready while not in STREAM is ignored.
// - ack and error are never high in the same cycle.
//
// TESTING
// - 2x2 stream: slot 0 holds 3f800000, 424951ec, c0200000, 3e000000; en,
//   m=2, n=2, ready=1 -> element_out shows those 4 words in order on 4
//   consecutive beats, then ack for 1 cycle; total en->ack is 6 cycles.
// - Backpressure: same matrix, ready toggled 1,0,0,1,... -> element_out and
//   valid stay stable through the stall cycles; exactly 4 beats; order
//   unchanged.
// - Partial shape: 4x4 slot, m=1, n=3 -> only [0][0], [0][1], [0][2] are
//   emitted, then ack. m=3, n=1 -> only [0][0], [1][0], [2][0] are emitted.
// - Bad size: m=0, or n=N+1 -> error pulses 1 cycle, valid never rises,
//   busy stays 0 after the error; the next legal en succeeds.
// - Reset mid-stream: drive rst=0 after 2 beats -> valid, busy and ack read
//   0 immediately; after release, a new en streams from [0][0].
// - Snapshot: a register-file write to the source slot during STREAM -> the
//   streamed data equals the values captured at FETCH; en pulsed during
//   STREAM is ignored.

Source files
------------

// File: rtl/mpu_store.sv
// Streams one register-file matrix row-major, one element per valid&ready beat; valid follows en by one FETCH cycle.
// Stalls hold element_out and counters; a request with an out-of-range shape produces a one-cycle error instead.
module mpu_store #(
  parameter int FP              = 32,
  parameter int M               = 4,
  parameter int N               = 4,
  parameter int MBITS           = 2,
  parameter int NBITS           = 2,
  parameter int MATRIX_REG_SIZE = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [MATRIX_REG_SIZE-1:0]    store_addr,
  input  logic [MBITS:0]                matrix_m_size,
  input  logic [NBITS:0]                matrix_n_size,
  output logic [MATRIX_REG_SIZE-1:0]    reg_store_addr,
  input  logic [M-1:0][N-1:0][FP-1:0]   matrix_in,
  output logic [FP-1:0]                 element_out,
  output logic                          valid,
  input  logic                          ready,
  output logic                          busy,
  output logic                          ack,
  output logic                          error
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    STREAM = 3'd2,
    DONE   = 3'd3,
    ERR    = 3'd4
  } state_e;

  localparam logic [MBITS:0]   M_MAX   = (MBITS+1)'(M);
  localparam logic [NBITS:0]   N_MAX   = (NBITS+1)'(N);
  localparam logic [MBITS:0]   M_ONE   = (MBITS+1)'(1);
  localparam logic [NBITS:0]   N_ONE   = (NBITS+1)'(1);
  localparam logic [MBITS-1:0] ROW_ONE = MBITS'(1);
  localparam logic [NBITS-1:0] COL_ONE = NBITS'(1);

  state_e                         state_q, state_d;
  logic [MATRIX_REG_SIZE-1:0]     addr_q, addr_d;
  logic [MBITS:0]                 m_q, m_d;
  logic [NBITS:0]                 n_q, n_d;
  logic [MBITS-1:0]               row_q, row_d;
  logic [NBITS-1:0]               col_q, col_d;
  logic [M-1:0][N-1:0][FP-1:0]    snap_q, snap_d;
  logic [FP-1:0]                  elem_q, elem_d;
  logic                           valid_q, valid_d;
  logic                           busy_q, busy_d;
  logic                           ack_q, ack_d;
  logic                           error_q, error_d;

  logic size_ok;
  logic last_col;
  logic last_row;

  assign size_ok  = (matrix_m_size != '0) && (matrix_m_size <= M_MAX) &&
                    (matrix_n_size != '0) && (matrix_n_size <= N_MAX);
  assign last_col = ({1'b0, col_q} == (n_q - N_ONE));
  assign last_row = ({1'b0, row_q} == (m_q - M_ONE));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    m_d     = m_q;
    n_d     = n_q;
    row_d   = row_q;
    col_d   = col_q;
    snap_d  = snap_q;

    case (state_q)
      IDLE: begin
        if (en) begin
          if (size_ok) begin
            state_d = FETCH;
            addr_d  = store_addr;
            m_d     = matrix_m_size;
            n_d     = matrix_n_size;
          end else begin
            state_d = ERR;
          end
        end
      end
      FETCH: begin
        // Snapshot isolates the stream from later register-file writes.
        snap_d  = matrix_in;
        row_d   = '0;
        col_d   = '0;
        state_d = STREAM;
      end
      STREAM: begin
        if (ready) begin
          if (last_col) begin
            col_d = '0;
            if (last_row) begin
              state_d = DONE;
            end else begin
              row_d = row_q + ROW_ONE;
            end
          end else begin
            col_d = col_q + COL_ONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    valid_d = (state_d == STREAM);
    busy_d  = (state_d != IDLE);
    ack_d   = (state_d == DONE);
    error_d = (state_d == ERR);
    elem_d  = valid_d ? snap_d[row_d][col_d] : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      m_q     <= '0;
      n_q     <= '0;
      row_q   <= '0;
      col_q   <= '0;
      snap_q  <= '0;
      elem_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      m_q     <= m_d;
      n_q     <= n_d;
      row_q   <= row_d;
      col_q   <= col_d;
      snap_q  <= snap_d;
      elem_q  <= elem_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      error_q <= error_d;
    end
  end

  assign reg_store_addr = addr_q;
  assign element_out    = elem_q;
  assign valid          = valid_q;
  assign busy           = busy_q;
  assign ack            = ack_q;
  assign error          = error_q;

endmodule
